mac_sequencer: RTL
==================

Name: mac_sequencer

Overview:
- Upstream feeder and downstream consumer for the team's sequential Booth multiplier.
- Accepts a stream of signed operand pairs over a valid/ready handshake and issues one multiply at a time.
- Waits a fixed multiplier latency, then captures the product and accumulates it.
- On the pair flagged last, presents the dot-product result over a valid/ready output handshake.

Parameters:
- WIDTH, 16: operand width; product width is 2*WIDTH.
- ACC_GUARD, 8: guard bits added above the product width; ACC_W = 2*WIDTH+ACC_GUARD.
- MUL_LATENCY, 2*WIDTH+3: cycles from the mul_start cycle to the first cycle mul_product is valid. Legal values are >= 2.
- CNT_W, 16: width of the pair counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair
- in_a  in  WIDTH  signed multiplier operand
- in_b  in  WIDTH  signed multiplicand operand
- in_last  in  1  marks final pair of a vector
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_multiplier  out  WIDTH  registered operand to multiplier
- mul_multiplicand  out  WIDTH  registered operand to multiplier
- mul_product  in  2*WIDTH  signed product from multiplier
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_acc  out  ACC_W  signed accumulated result
- out_count  out  CNT_W  number of pairs accumulated into out_acc
- out_ovf  out  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset values: state IDLE; mul_start=0; mul_multiplier=0; mul_multiplicand=0; out_valid=0; out_acc=0; out_count=0; out_ovf=0. in_ready=1 after reset.
- Reset is honoured mid-operation: any in-flight multiply is abandoned and its product is never accumulated.
- States: IDLE, ISSUE, WAIT, ACCUM, OUTPUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register in_a→mul_multiplier, in_b→mul_multiplicand, latch in_last; go to ISSUE.
- ISSUE:
  - mul_start=1 for exactly this cycle; in_ready=0.
  - Load the wait counter; go to WAIT.
- WAIT:
  - Decrement the wait counter.
  - ACCUM must occur exactly MUL_LATENCY cycles after the ISSUE cycle.
  - For MUL_LATENCY=2, WAIT lasts one cycle.
- ACCUM:
  - acc <= acc + sign_extend(mul_product, ACC_W); count <= count+1.
  - If the latched last=1, go to OUTPUT; else go to IDLE.
- OUTPUT:
  - out_valid=1; out_acc and out_count are held stable while out_valid=1 && !out_ready.
  - On out_valid&&out_ready: clear acc, count and out_ovf to 0, then go to IDLE in the next cycle.
  - in_ready=0 throughout OUTPUT.
- mul_multiplier and mul_multiplicand remain stable from ISSUE through ACCUM inclusive.
- in_ready is 0 in every state except IDLE, so at most one pair is in flight.
- Throughput: one pair per MUL_LATENCY+2 cycles when in_valid is held high.
- out_acc is a direct view of the accumulator register.
- The accumulator is two's complement; without the optional feature, overflow wraps modulo 2^ACC_W.
- out_count wraps modulo 2^CNT_W.
- A vector of a single pair with in_last=1 is legal; its result is that pair's product.
- Input values while in_ready=0 are ignored. Inputs are never sampled except in IDLE.

Optional Feature:
- Macro: MAC_SATURATE_EN.
- Defined:
  - ACCUM computes the sum at ACC_W+1 bits.
  - On positive overflow it clamps to 2^(ACC_W-1)-1; on negative overflow to -2^(ACC_W-1).
  - On overflow, out_ovf is set and stays 1 until the output handshake or reset.
- Undefined:
  - Wrap-around accumulation.
  - out_ovf is tied to 0.

Test Plan:
- (WIDTH=16, MUL_LATENCY=35, behavioural multiplier model) Reset then idle: out_valid=0, out_acc=0, out_count=0, in_ready=1, mul_start never pulses.
- Single pair a=3, b=-5, last=1: mul_start is high for one cycle, ACCUM occurs 35 cycles after ISSUE, out_acc=-15, out_count=1; out_valid holds for 3 cycles with out_ready=0 and out_acc stays -15.
- Pairs (100,200), (-7,7), (-32768,-32768 last) back-to-back with in_valid held: out_acc=20000-49+1073741824=1073761775, out_count=3; in_ready is high once per 37 cycles.
- Assert rst 10 cycles into WAIT: all outputs return to reset values immediately. A following pair (2,2,last) yields out_acc=4, out_count=1.
- With MAC_SATURATE_EN and ACC_GUARD=0: pairs (-32768,-32768) x2, last on the second: out_acc=2147483647, out_ovf=1. After the handshake, out_ovf=0. Without the macro, out_acc=-2147483648 and out_ovf=0.
- in_valid toggling randomly and out_ready stalling randomly over 1000 pairs: the out_acc sequence matches the reference model, no pair is dropped or duplicated, and operands stay stable ISSUE→ACCUM.

Source files
------------

// File: rtl/mac_sequencer_if.sv
// Handshake bundle joining the MAC sequencer to its operand source, the
// sequential Booth multiplier and the result consumer.
interface mac_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [WIDTH-1:0]   in_a;
    logic signed [WIDTH-1:0]   in_b;
    logic                      in_last;
    logic                      mul_start;
    logic signed [WIDTH-1:0]   mul_multiplier;
    logic signed [WIDTH-1:0]   mul_multiplicand;
    logic signed [2*WIDTH-1:0] mul_product;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [ACC_W-1:0]   out_acc;
    logic [CNT_W-1:0]          out_count;
    logic                      out_ovf;

    // Environment side: operand source, multiplier and result consumer.
    modport master (
        output in_valid, in_a, in_b, in_last, mul_product, out_ready,
        input  in_ready, mul_start, mul_multiplier, mul_multiplicand,
               out_valid, out_acc, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, mul_product, out_ready,
        output in_ready, mul_start, mul_multiplier, mul_multiplicand,
               out_valid, out_acc, out_count, out_ovf
    );
endinterface

// File: rtl/mac_sequencer.sv
// Feeds one operand pair at a time to a fixed-latency multiplier and accumulates
// the products into a dot product. `MAC_SATURATE_EN selects saturating accumulation.
module mac_sequencer #(
    parameter int WIDTH       = 16,
    parameter int ACC_GUARD   = 8,
    parameter int MUL_LATENCY = 2*WIDTH+3,
    parameter int CNT_W       = 16
) (
    input logic            clk,
    input logic            rst,
    mac_sequencer_if.slave bus
);
    localparam int ACC_W  = 2*WIDTH + ACC_GUARD;
    localparam int WAIT_W = $clog2(MUL_LATENCY) + 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACCUM, OUTPUT} state_t;

    state_t                  state, state_nx;
    logic [WAIT_W-1:0]       wait_cnt;
    logic                    last_q;
    logic signed [ACC_W-1:0] acc, acc_nx;
    logic [CNT_W-1:0]        count;
    logic signed [ACC_W:0]   prod_x, sum_x;
    logic                    ovf_hit;

    // One extra bit lets the saturating build see the true sign of the sum.
    assign prod_x = (ACC_W+1)'(bus.mul_product);
    assign sum_x  = {acc[ACC_W-1], acc} + prod_x;

`ifdef MAC_SATURATE_EN
    logic ovf;

    always_comb begin
        acc_nx  = sum_x[ACC_W-1:0];
        ovf_hit = 1'b0;
        if (sum_x[ACC_W] != sum_x[ACC_W-1]) begin
            ovf_hit = 1'b1;
            acc_nx  = sum_x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (state == ACCUM && ovf_hit)
            ovf <= 1'b1;
        else if (state == OUTPUT && bus.out_ready)
            ovf <= 1'b0;
    end

    assign bus.out_ovf = ovf;
`else
    assign acc_nx      = sum_x[ACC_W-1:0];
    assign ovf_hit     = 1'b0;
    assign bus.out_ovf = 1'b0;
`endif

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.mul_start = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nx = ISSUE;
            end
            ISSUE: begin
                bus.mul_start = 1'b1;
                state_nx      = WAIT;
            end
            WAIT:   if (wait_cnt == '0) state_nx = ACCUM;
            ACCUM:  state_nx = last_q ? OUTPUT : IDLE;
            OUTPUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // WAIT spans MUL_LATENCY-1 cycles so ACCUM lands on the first valid product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            wait_cnt             <= '0;
            last_q               <= 1'b0;
            bus.mul_multiplier   <= '0;
            bus.mul_multiplicand <= '0;
            acc                  <= '0;
            count                <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (bus.in_valid) begin
                    bus.mul_multiplier   <= bus.in_a;
                    bus.mul_multiplicand <= bus.in_b;
                    last_q               <= bus.in_last;
                end
                ISSUE: wait_cnt <= WAIT_W'(MUL_LATENCY - 2);
                WAIT:  wait_cnt <= wait_cnt - WAIT_W'(1);
                ACCUM: begin
                    acc   <= acc_nx;
                    count <= count + CNT_W'(1);
                end
                OUTPUT: if (bus.out_ready) begin
                    acc   <= '0;
                    count <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_acc   = acc;
    assign bus.out_count = count;
endmodule
